bus_dev_port: RTL

- Per-device endpoint between a device driver/consumer and the bus generator/arbiter.
- TX side: buffers outgoing packets in a FIFO and presents them to the arbiter with the pndng/pop/D_pop handshake.
- RX side: captures packets the arbiter delivers via push/D_push, filters them by destination ID, and queues them for the device.
- One instance per device; DISPOSITIVOS instances surround the arbiter.

---
 rtl/bus_dev_port.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/bus_dev_port.sv
// bus_dev_port: per-device bus endpoint.
// TX: FWFT FIFO of outgoing packets presented to the arbiter via pndng/pop/D_pop.
// RX: packets delivered via push/D_push, filtered by destination ID
//     (DEV_ID or BCAST_ID), queued in a FWFT FIFO for the device.
// Optional: define BUS_DEV_PORT_DROP_CNT_EN to add saturating 16-bit drop
// counters tx_drop_cnt / rx_drop_cnt.
module bus_dev_port #(
  parameter int          PCKG_SZ  = 24,
  parameter int          DEPTH    = 8,
  parameter logic [7:0]  DEV_ID   = 8'd0,
  parameter logic [7:0]  BCAST_ID = 8'hFF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [PCKG_SZ-1:0]           wr_data,
  output logic                         tx_full,
  output logic [$clog2(DEPTH+1)-1:0]   tx_count,
  output logic                         pndng,
  output logic [PCKG_SZ-1:0]           D_pop,
  input  logic                         pop,
  input  logic                         push,
  input  logic [PCKG_SZ-1:0]           D_push,
  input  logic                         rd_en,
  output logic [PCKG_SZ-1:0]           rd_data,
  output logic                         rx_valid,
  output logic                         rx_ovf,
`ifdef BUS_DEV_PORT_DROP_CNT_EN
  output logic [15:0]                  tx_drop_cnt,
  output logic [15:0]                  rx_drop_cnt,
`endif
  output logic                         id_err
);

  localparam int             AW       = $clog2(DEPTH);
  localparam int             CW       = $clog2(DEPTH+1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

  // ---------------------------------------------------------------- TX path
  logic [PCKG_SZ-1:0] tx_mem [DEPTH];
  logic [AW-1:0]      tx_wr_ptr_q, tx_wr_ptr_d;
  logic [AW-1:0]      tx_rd_ptr_q, tx_rd_ptr_d;
  logic [CW-1:0]      tx_cnt_q, tx_cnt_d;
  logic               tx_pop_ok, tx_wr_ok;

  // TX accept decisions; a pop frees a slot so a full FIFO may take a write.
  always_comb begin
    tx_pop_ok   = pop && (tx_cnt_q != '0);
    tx_wr_ok    = wr_en && ((tx_cnt_q != FULL_CNT) || tx_pop_ok);
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_cnt_d    = tx_cnt_q;
    if (tx_wr_ok)  tx_wr_ptr_d = tx_wr_ptr_q + AW'(1);
    if (tx_pop_ok) tx_rd_ptr_d = tx_rd_ptr_q + AW'(1);
    if (tx_wr_ok && !tx_pop_ok)      tx_cnt_d = tx_cnt_q + CW'(1);
    else if (!tx_wr_ok && tx_pop_ok) tx_cnt_d = tx_cnt_q - CW'(1);
  end

  // TX storage; contents need no reset since the count gates visibility.
  always_ff @(posedge clk) begin
    if (tx_wr_ok) tx_mem[tx_wr_ptr_q] <= wr_data;
  end

  // TX pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
    end else begin
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_cnt_q    <= tx_cnt_d;
    end
  end

  assign pndng    = (tx_cnt_q != '0);
  assign tx_full  = (tx_cnt_q == FULL_CNT);
  assign tx_count = tx_cnt_q;
  assign D_pop    = pndng ? tx_mem[tx_rd_ptr_q] : '0;

  // ---------------------------------------------------------------- RX path
  logic [PCKG_SZ-1:0] rx_mem [DEPTH];
  logic [AW-1:0]      rx_wr_ptr_q, rx_wr_ptr_d;
  logic [AW-1:0]      rx_rd_ptr_q, rx_rd_ptr_d;
  logic [CW-1:0]      rx_cnt_q, rx_cnt_d;
  logic               rx_ovf_q, rx_ovf_d;
  logic               id_err_q, id_err_d;
  logic [7:0]         rx_hdr;
  logic               rx_match, rx_rd_ok, rx_store, rx_over;

  // RX filter, overflow detection and FIFO bookkeeping.
  always_comb begin
    rx_hdr      = D_push[PCKG_SZ-1 -: 8];
    rx_match    = (rx_hdr == DEV_ID) || (rx_hdr == BCAST_ID);
    rx_rd_ok    = rd_en && (rx_cnt_q != '0);
    rx_store    = push && rx_match && ((rx_cnt_q != FULL_CNT) || rx_rd_ok);
    rx_over     = push && rx_match && !rx_store;
    id_err_d    = push && !rx_match;
    rx_ovf_d    = rx_ovf_q || rx_over;
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_cnt_d    = rx_cnt_q;
    if (rx_store) rx_wr_ptr_d = rx_wr_ptr_q + AW'(1);
    if (rx_rd_ok) rx_rd_ptr_d = rx_rd_ptr_q + AW'(1);
    if (rx_store && !rx_rd_ok)      rx_cnt_d = rx_cnt_q + CW'(1);
    else if (!rx_store && rx_rd_ok) rx_cnt_d = rx_cnt_q - CW'(1);
  end

  // RX storage; push data lands here and shows on rd_data next cycle.
  always_ff @(posedge clk) begin
    if (rx_store) rx_mem[rx_wr_ptr_q] <= D_push;
  end

  // RX pointers, occupancy and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
      rx_ovf_q    <= 1'b0;
      id_err_q    <= 1'b0;
    end else begin
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_ovf_q    <= rx_ovf_d;
      id_err_q    <= id_err_d;
    end
  end

  assign rx_valid = (rx_cnt_q != '0);
  assign rd_data  = rx_valid ? rx_mem[rx_rd_ptr_q] : '0;
  assign rx_ovf   = rx_ovf_q;
  assign id_err   = id_err_q;

`ifdef BUS_DEV_PORT_DROP_CNT_EN
  // ------------------------------------------------------- drop counters
  logic [15:0] tx_drop_q, tx_drop_d;
  logic [15:0] rx_drop_q, rx_drop_d;

  // Saturating counts of rejected TX writes and discarded RX pushes.
  always_comb begin
    tx_drop_d = tx_drop_q;
    rx_drop_d = rx_drop_q;
    if (wr_en && !tx_wr_ok && (tx_drop_q != 16'hFFFF))
      tx_drop_d = tx_drop_q + 16'd1;
    if ((rx_over || id_err_d) && (rx_drop_q != 16'hFFFF))
      rx_drop_d = rx_drop_q + 16'd1;
  end

  // Drop counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_drop_q <= '0;
      rx_drop_q <= '0;
    end else begin
      tx_drop_q <= tx_drop_d;
      rx_drop_q <= rx_drop_d;
    end
  end

  assign tx_drop_cnt = tx_drop_q;
  assign rx_drop_cnt = rx_drop_q;
`endif

endmodule
